// File: rtl/sysid_checker.sv
`default_nettype none
// ============================================================================
//  Module      : sysid_checker
//  Description : Avalon-MM read master that fetches the system ID word
//                (address 0) and build timestamp (address 1), latches them,
//                and compares each against the expected image values. Reports
//                pass/fail/timeout to board status logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h7A476E47,
  parameter logic [31:0] EXPECTED_TS    = 32'h4DD441FC,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_ID  = 2'd1,
    ST_RD_TS  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Stall limit in the counter's own width (legal range is 1..65535).
  localparam logic [15:0] c_timeout_lim = 16'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic        pending_q, pending_d;
  logic        armed_q, armed_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  logic [15:0] w_stall_inc;
  logic        w_limit_hit;

  // Next-state and datapath update for the read sequence.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    // The automatic launch waits one edge after reset release so it never
    // acts on the edge that coincides with reset deassertion.
    armed_d     = 1'b1;
    stall_cnt_d = stall_cnt_q;
    id_ok_d     = id_ok_q;
    ts_ok_d     = ts_ok_q;
    timeout_d   = timeout_q;
    id_value_d  = id_value_q;
    ts_value_d  = ts_value_q;

    w_stall_inc = stall_cnt_q + 16'd1;
    w_limit_hit = (w_stall_inc >= c_timeout_lim);

    case (state_q)
      ST_IDLE: begin
        if (start || (pending_q && armed_q)) begin
          state_d     = ST_RD_ID;
          pending_d   = 1'b0;
          id_ok_d     = 1'b0;
          ts_ok_d     = 1'b0;
          timeout_d   = 1'b0;
          stall_cnt_d = 16'd0;
        end
      end

      ST_RD_ID, ST_RD_TS: begin
        if (!avm_waitrequest) begin
          stall_cnt_d = 16'd0;
          if (state_q == ST_RD_ID) begin
            id_value_d = avm_readdata;
            state_d    = ST_RD_TS;
          end else begin
            ts_value_d = avm_readdata;
            id_ok_d    = (id_value_q == EXPECTED_ID);
            ts_ok_d    = (avm_readdata == EXPECTED_TS);
            state_d    = ST_FINISH;
          end
        end else if (w_limit_hit) begin
          // Abort: captured words are kept, both verdicts forced to fail.
          stall_cnt_d = 16'd0;
          timeout_d   = 1'b1;
          id_ok_d     = 1'b0;
          ts_ok_d     = 1'b0;
          state_d     = ST_FINISH;
        end else begin
          stall_cnt_d = w_stall_inc;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pending_q   <= AUTO_START;
      armed_q     <= 1'b0;
      stall_cnt_q <= 16'd0;
      id_ok_q     <= 1'b0;
      ts_ok_q     <= 1'b0;
      timeout_q   <= 1'b0;
      id_value_q  <= 32'd0;
      ts_value_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      armed_q     <= armed_d;
      stall_cnt_q <= stall_cnt_d;
      id_ok_q     <= id_ok_d;
      ts_ok_q     <= ts_ok_d;
      timeout_q   <= timeout_d;
      id_value_q  <= id_value_d;
      ts_value_q  <= ts_value_d;
    end
  end

  // Bus strobes and status decode straight from the state register, so they
  // stay stable across wait states and clear at once on reset.
  always_comb begin
    avm_read    = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);
    avm_address = (state_q == ST_RD_TS);
    busy        = avm_read;
    done        = (state_q == ST_FINISH);
    id_ok       = id_ok_q;
    ts_ok       = ts_ok_q;
    timeout     = timeout_q;
    id_value    = id_value_q;
    ts_value    = ts_value_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_sysid_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_sysid_checker
//  Description : Self-checking bench for sysid_checker with a behavioural
//                sysid slave and a transaction-level result model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h7A476E47;
  localparam logic [31:0] EXP_TS = 32'h4DD441FC;
  localparam int          T      = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic start0 = 1'b0;

  logic        avm_address, avm_read, avm_waitrequest;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] avm_readdata, id_value, ts_value;

  logic        avm_address0, avm_read0, busy0, done0, id_ok0, ts_ok0, timeout0;
  logic [31:0] id_value0, ts_value0;

  // Slave configuration: words returned and wait states per read.
  logic [31:0] sl_id_word = EXP_ID;
  logic [31:0] sl_ts_word = EXP_TS;
  int          sl_id_stall = 0;
  int          sl_ts_stall = 0;
  int          sl_cnt;

  // Reference copies of the latched words.
  logic [31:0] ref_id = 32'd0;
  logic [31:0] ref_ts = 32'd0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sysid_checker #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
                  .TIMEOUT_CYCLES(T), .AUTO_START(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok),
    .timeout(timeout), .id_value(id_value), .ts_value(ts_value));

  sysid_checker #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
                  .TIMEOUT_CYCLES(T), .AUTO_START(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start0),
    .avm_address(avm_address0), .avm_read(avm_read0),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy0), .done(done0), .id_ok(id_ok0), .ts_ok(ts_ok0),
    .timeout(timeout0), .id_value(id_value0), .ts_value(ts_value0));

  // Behavioural sysid slave: inserts the configured wait states per read.
  always_comb begin
    avm_readdata    = avm_address ? sl_ts_word : sl_id_word;
    avm_waitrequest = avm_read && (sl_cnt < (avm_address ? sl_ts_stall : sl_id_stall));
  end

  // Wait-state counter of the slave, restarted for every new read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sl_cnt <= 0;
    else if (avm_read && avm_waitrequest) sl_cnt <= sl_cnt + 1;
    else sl_cnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Follows one sequence from the cycle after launch until done.
  task automatic observe(input bit poke_mid, input bit poke_done,
                         output int lat, output int viol, output int acc);
    bit prev_rw = 1'b0;
    bit prev_addr = 1'b0;
    bit got_done = 1'b0;
    lat = 1; viol = 0; acc = 0;
    for (int g = 0; g < 200; g++) begin
      if (prev_rw && !done && (!avm_read || avm_address != prev_addr)) viol++;
      if (!done && !busy) viol++;
      if (avm_read && !avm_waitrequest) begin
        if (avm_address && acc[0] == 1'b0) viol++;
        acc = acc | (avm_address ? 2 : 1);
      end
      prev_rw   = avm_read && avm_waitrequest;
      prev_addr = avm_address;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      start = poke_mid && (lat == 2);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (!got_done) check("done_never_seen", 32'd0, 32'd1);
    if (poke_done) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  // Predicts the outcome of one sequence from stall counts and words.
  task automatic check_result(input string tag, input logic [31:0] id_w, input logic [31:0] ts_w,
                              input int s1, input int s2, input int lat, input int viol, input int acc);
    int exp_lat, exp_acc;
    bit exp_to;
    if (s1 >= T) begin
      exp_lat = T + 1; exp_to = 1'b1; exp_acc = 0;
    end else if (s2 >= T) begin
      exp_lat = s1 + T + 2; exp_to = 1'b1; exp_acc = 1; ref_id = id_w;
    end else begin
      exp_lat = s1 + s2 + 3; exp_to = 1'b0; exp_acc = 3; ref_id = id_w; ref_ts = ts_w;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_reads"}, 32'(acc), 32'(exp_acc));
    check({tag, "_bus_rules"}, 32'(viol), 32'd0);
    check({tag, "_flags"}, {29'd0, timeout, id_ok, ts_ok},
          {29'd0, exp_to, !exp_to && (ref_id == EXP_ID), !exp_to && (ref_ts == EXP_TS)});
    check({tag, "_id_value"}, id_value, ref_id);
    check({tag, "_ts_value"}, ts_value, ref_ts);
    check({tag, "_idle_at_done"}, {30'd0, busy, avm_read}, 32'd0);
  endtask

  task automatic run_seq(input string tag, input logic [31:0] id_w, input logic [31:0] ts_w,
                         input int s1, input int s2, input bit poke_mid, input bit poke_done);
    int lat, viol, acc;
    sl_id_word = id_w; sl_ts_word = ts_w; sl_id_stall = s1; sl_ts_stall = s2;
    @(posedge clk);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    observe(poke_mid, poke_done, lat, viol, acc);
    check_result(tag, id_w, ts_w, s1, s2, lat, viol, acc);
  endtask

  initial begin
    int lat, viol, acc, cnt, s1, s2;
    logic [31:0] idw, tsw;

    // Reset state of both instances.
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {25'd0, avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}, 32'd0);
    check("reset_values", id_value | ts_value, 32'd0);
    check("reset_outputs0", {30'd0, avm_read0, busy0}, 32'd0);

    // Automatic launch after release.
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("auto_first_edge_read", {31'd0, avm_read}, 32'd0);
    @(posedge clk); #1;
    check("auto_second_edge_read", {30'd0, avm_read, avm_address}, 32'd2);
    observe(1'b0, 1'b0, lat, viol, acc);
    check_result("auto", EXP_ID, EXP_TS, 0, 0, lat, viol, acc);

    // The AUTO_START=0 instance stays silent.
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (avm_read0 || busy0) cnt++;
    end
    check("noauto_quiet", 32'(cnt), 32'd0);

    // Directed cases.
    run_seq("ts_bad", EXP_ID, 32'h4DD441FD, 0, 0, 1'b0, 1'b0);
    run_seq("waits_4_2", EXP_ID, EXP_TS, 4, 2, 1'b0, 1'b0);
    run_seq("stuck", EXP_ID, EXP_TS, 1000, 0, 1'b0, 1'b0);
    run_seq("pokes", EXP_ID, EXP_TS, 3, 1, 1'b1, 1'b1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (avm_read || done || busy) cnt++;
    end
    check("pokes_not_queued", 32'(cnt), 32'd0);
    run_seq("ts_stuck", 32'h12345678, EXP_TS, 1, 1000, 1'b0, 1'b0);

    // Randomised sequences.
    for (int i = 0; i < 16; i++) begin
      idw = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
      tsw = ($urandom_range(0, 3) == 0) ? (EXP_TS ^ (32'd1 << $urandom_range(0, 31))) : EXP_TS;
      s1  = ($urandom_range(0, 5) == 0) ? $urandom_range(T - 1, T + 3) : $urandom_range(0, 4);
      s2  = ($urandom_range(0, 5) == 0) ? $urandom_range(T - 1, T + 3) : $urandom_range(0, 4);
      run_seq("rand", idw, tsw, s1, s2, 1'b0, 1'b0);
    end

    // Reset while the timestamp read is stalled.
    sl_id_word = EXP_ID; sl_ts_word = EXP_TS; sl_id_stall = 0; sl_ts_stall = 5;
    @(posedge clk);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    check("in_rd_ts", {30'd0, avm_read, avm_address}, 32'd3);
    #1 reset = 1'b1;
    #1;
    check("async_reset_outputs", {25'd0, avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}, 32'd0);
    check("async_reset_values", id_value | ts_value, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (avm_read0) cnt++;
    end
    check("noauto_after_reset", 32'(cnt), 32'd0);
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    check("noauto_start_read", {30'd0, avm_read0, avm_address0}, 32'd2);
    repeat (20) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
